mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width; wstrb width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_MAX, default 4: consecutive fetch losses before fetch is forced to win.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Ports: clk  in  1  clock, all state on rising edge.
REQ-006 Ports: rst_n  in  1  asynchronous active-low reset.
REQ-007 Ports: if_req / if_addr  in  1 / ADDR_W  fetch read request and address, held until if_gnt.
REQ-008 Ports: mem_req / mem_we / mem_addr / mem_wdata / mem_wstrb  in  1 / 1 / ADDR_W / DATA_W / DATA_W/8  data-stage request, held until mem_gnt.
REQ-009 Ports: if_gnt / mem_gnt  out  1  one-cycle acceptance pulse per requester.
REQ-010 Ports: if_rvalid / mem_rvalid  out  1  one-cycle response pulse; if_rdata / mem_rdata  out  DATA_W.
REQ-011 Ports: bus_req / bus_we / bus_addr / bus_wdata / bus_wstrb  out  shared-port request and payload.
REQ-012 Ports: bus_gnt / bus_rvalid  in  1; bus_rdata  in  DATA_W  shared-port handshake and response.
REQ-013 Ports: busy  out  1  state != IDLE; owner  out  1  0 = fetch, 1 = data for the in-flight transaction.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, RSP; exactly one transaction outstanding on the bus.
REQ-015 Arbitration event: state IDLE, or state RSP with bus_rvalid=1, while if_req or mem_req is high.
REQ-016 At an arbitration event, mem wins when mem_req=1 and starve_cnt < STARVE_MAX; otherwise fetch wins if if_req=1.
REQ-017 Winner SHALL get a gnt pulse that cycle; payload latched into internal registers; owner registered; next state REQ.
REQ-018 A requester's gnt and its rvalid SHALL never occur in the same cycle for the same transaction; a new gnt may coincide with the previous transaction's rvalid.
REQ-019 starve_cnt (3 bits, saturating at STARVE_MAX) SHALL increment when mem wins while if_req=1, and clear when fetch wins.
REQ-020 REQ: bus_req=1, bus_* driven only from latched registers; payload stable until bus_gnt; on bus_gnt next state RSP.
REQ-021 bus_req SHALL be 0 in IDLE and RSP; bus_we=0 when owner=fetch.
REQ-022 RSP: on bus_rvalid, the owner's rvalid=1 and its rdata=bus_rdata combinationally; the other rvalid stays 0.
REQ-023 Writes also complete by bus_rvalid; mem_rdata SHALL forward bus_rdata unmodified (content don't-care).
REQ-024 RSP with bus_rvalid and no pending request: next state IDLE.
REQ-025 bus_gnt outside REQ and bus_rvalid outside RSP SHALL be ignored (no pulses, no state change).
REQ-026 if_rdata/mem_rdata SHALL be 0 whenever the corresponding rvalid is 0.
REQ-027 Request-to-bus_req latency: exactly one cycle after gnt.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, starve_cnt=0, owner=0, latched payload=0.
REQ-029 During reset all outputs SHALL be 0: gnts, rvalids, rdata, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, busy.
REQ-030 Reset mid-transaction SHALL abandon it; a bus_rvalid arriving after reset release in IDLE produces no response.

Verification
REQ-031 Single fetch: if_req=1, if_addr=0x100; bus_gnt 2 cycles after bus_req, bus_rvalid 3 cycles later with 0x00000013 -> if_gnt at cycle 0, bus_req cycles 1-3, bus_addr=0x100, if_rvalid=1 with if_rdata=0x00000013 exactly once.
REQ-032 Simultaneous: if_req and mem_req (mem_we=1, addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF) same cycle -> mem_gnt first, bus_we=1; if_gnt on the cycle mem_rvalid pulses.
REQ-033 Starvation: mem_req and if_req held high continuously, STARVE_MAX=4 -> owner sequence 1,1,1,1,0,1,...
REQ-034 Spurious: bus_rvalid=1 in IDLE and bus_gnt=1 in RSP -> no rvalid pulse, no state change.
REQ-035 Reset mid-op: rst_n=0 during REQ -> bus_req=0 same cycle; after release, late bus_rvalid ignored; next if_req serviced normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port: fetch (read-only) and data stage.
// One bus transaction outstanding at a time; data stage has priority with fetch starvation relief.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                if_gnt,
  output logic                mem_gnt,
  output logic                if_rvalid,
  output logic                mem_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int         STRB_W     = DATA_W / 8;
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          starve_cnt_reg, starve_cnt_next;
  logic                owner_reg, owner_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [STRB_W-1:0]   wstrb_reg, wstrb_next;

  logic arb_event;
  logic mem_win;
  logic if_win;
  logic rsp_done;

  // A response cycle doubles as an arbitration slot so back-to-back requests lose no cycle.
  assign rsp_done  = (state_reg == RSP) && bus_rvalid;
  assign arb_event = ((state_reg == IDLE) || rsp_done) && (if_req || mem_req);
  assign mem_win   = arb_event && mem_req && (starve_cnt_reg < STARVE_LIM);
  assign if_win    = arb_event && !mem_win && if_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      owner_reg      <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      owner_reg      <= owner_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      wstrb_reg      <= wstrb_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    owner_next      = owner_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    wstrb_next      = wstrb_reg;

    unique case (state_reg)
      IDLE:    if (mem_win || if_win) state_next = REQ;
      REQ:     if (bus_gnt) state_next = RSP;
      RSP:     if (bus_rvalid) state_next = (mem_win || if_win) ? REQ : IDLE;
      default: state_next = IDLE;
    endcase

    // mem_win already implies starve_cnt < STARVE_MAX, so the increment saturates there.
    if (mem_win) begin
      owner_next = 1'b1;
      we_next    = mem_we;
      addr_next  = mem_addr;
      wdata_next = mem_wdata;
      wstrb_next = mem_wstrb;
      if (if_req) starve_cnt_next = starve_cnt_reg + 3'd1;
    end else if (if_win) begin
      owner_next      = 1'b0;
      we_next         = 1'b0;
      addr_next       = if_addr;
      wdata_next      = '0;
      wstrb_next      = '0;
      starve_cnt_next = '0;
    end
  end

  // Grants are combinational from the request inputs, so they need explicit masking in reset.
  assign if_gnt     = rst_n && if_win;
  assign mem_gnt    = rst_n && mem_win;
  assign if_rvalid  = rst_n && rsp_done && !owner_reg;
  assign mem_rvalid = rst_n && rsp_done && owner_reg;
  assign if_rdata   = if_rvalid  ? bus_rdata : '0;
  assign mem_rdata  = mem_rvalid ? bus_rdata : '0;

  assign bus_req   = (state_reg == REQ);
  assign bus_we    = we_reg;
  assign bus_addr  = addr_reg;
  assign bus_wdata = wdata_reg;
  assign bus_wstrb = wstrb_reg;
  assign busy      = (state_reg != IDLE);
  assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the main flows,
// plus hand sequences for starvation relief and reset in the middle of a transaction.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        if_gnt;
  logic        mem_gnt;
  logic        if_rvalid;
  logic        mem_rvalid;
  logic [31:0] if_rdata;
  logic [31:0] mem_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        busy;
  logic        owner;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .if_gnt(if_gnt), .mem_gnt(mem_gnt),
    .if_rvalid(if_rvalid), .mem_rvalid(mem_rvalid),
    .if_rdata(if_rdata), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        if_gnt;
    logic        mem_gnt;
    logic        if_rvalid;
    logic        mem_rvalid;
    logic [31:0] if_rdata;
    logic [31:0] mem_rdata;
    logic        bus_req;
    logic        busy;
    logic        owner;
  } out_t;

  typedef struct {
    string       name;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    out_t        exp;
    logic        chk_pay;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic        chk_wd;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(
      input string nm, input logic ir, input logic [31:0] ia,
      input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] md, input logic [3:0] ms,
      input logic bg, input logic brv, input logic [31:0] brd,
      input logic eig, input logic emg, input logic eirv, input logic emrv,
      input logic [31:0] eird, input logic [31:0] emrd,
      input logic ebr, input logic eby, input logic eow,
      input logic cp, input logic ewe, input logic [31:0] ead,
      input logic cw, input logic [31:0] ewd, input logic [3:0] ews);
    vec_t v;
    v.name = nm; v.if_req = ir; v.if_addr = ia;
    v.mem_req = mr; v.mem_we = mw; v.mem_addr = ma; v.mem_wdata = md; v.mem_wstrb = ms;
    v.bus_gnt = bg; v.bus_rvalid = brv; v.bus_rdata = brd;
    v.exp = {eig, emg, eirv, emrv, eird, emrd, ebr, eby, eow};
    v.chk_pay = cp; v.exp_we = ewe; v.exp_addr = ead;
    v.chk_wd = cw; v.exp_wdata = ewd; v.exp_wstrb = ews;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    out_t act;
    if_req = v.if_req; if_addr = v.if_addr;
    mem_req = v.mem_req; mem_we = v.mem_we; mem_addr = v.mem_addr;
    mem_wdata = v.mem_wdata; mem_wstrb = v.mem_wstrb;
    bus_gnt = v.bus_gnt; bus_rvalid = v.bus_rvalid; bus_rdata = v.bus_rdata;
    @(negedge clk);
    act = {if_gnt, mem_gnt, if_rvalid, mem_rvalid, if_rdata, mem_rdata, bus_req, busy, owner};
    chk(v.name, act, v.exp);
    if (v.chk_pay) chk({v.name, "_pay"}, {bus_we, bus_addr}, {v.exp_we, v.exp_addr});
    if (v.chk_wd) chk({v.name, "_wd"}, {bus_wdata, bus_wstrb}, {v.exp_wdata, v.exp_wstrb});
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0;
    mem_wdata = 0; mem_wstrb = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int own_q[$];
    logic [31:0] addr_q[$];
    int waited;

    // Reset with every input asserted: all outputs must stay low.
    rst_n = 0;
    if_req = 1; if_addr = 32'h123; mem_req = 1; mem_we = 1; mem_addr = 32'h456;
    mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
    #12;
    chk("reset_ctl", {if_gnt, mem_gnt, if_rvalid, mem_rvalid, bus_req, bus_we, busy, owner}, 8'h00);
    chk("reset_data", {if_rdata, mem_rdata, bus_addr, bus_wdata, bus_wstrb}, '0);
    idle_inputs();
    #10 rst_n = 1;
    @(posedge clk); #1;

    // Single fetch: bus_gnt two cycles after bus_req, bus_rvalid three cycles after bus_gnt.
    vecs.push_back(mk("f_gnt",   1,'h100, 0,0,0,0,0, 0,0,0,            1,0,0,0,0,0,     0,0,0, 0,0,0,       0,0,0));
    vecs.push_back(mk("f_req1",  0,0,     0,0,0,0,0, 0,0,0,            0,0,0,0,0,0,     1,1,0, 1,0,'h100,   0,0,0));
    vecs.push_back(mk("f_req2",  0,0,     0,0,0,0,0, 0,0,0,            0,0,0,0,0,0,     1,1,0, 1,0,'h100,   0,0,0));
    vecs.push_back(mk("f_req3",  0,0,     0,0,0,0,0, 1,0,0,            0,0,0,0,0,0,     1,1,0, 1,0,'h100,   0,0,0));
    vecs.push_back(mk("f_rsp1",  0,0,     0,0,0,0,0, 0,0,0,            0,0,0,0,0,0,     0,1,0, 0,0,0,       0,0,0));
    vecs.push_back(mk("f_rsp2",  0,0,     0,0,0,0,0, 0,0,'hFFFFFFFF,   0,0,0,0,0,0,     0,1,0, 0,0,0,       0,0,0));
    vecs.push_back(mk("f_rv",    0,0,     0,0,0,0,0, 0,1,'h13,         0,0,1,0,'h13,0,  0,1,0, 0,0,0,       0,0,0));
    vecs.push_back(mk("f_idle",  0,0,     0,0,0,0,0, 0,0,0,            0,0,0,0,0,0,     0,0,0, 0,0,0,       0,0,0));
    // Simultaneous requests: data stage wins, fetch granted on the write's response cycle.
    vecs.push_back(mk("m_arb",   1,'h200, 1,1,'h2000,'hDEADBEEF,'hF, 0,0,0,  0,1,0,0,0,0,  0,0,0, 0,0,0,       0,0,0));
    vecs.push_back(mk("m_req",   1,'h200, 0,0,0,0,0, 1,0,0,            0,0,0,0,0,0,     1,1,1, 1,1,'h2000,  1,'hDEADBEEF,'hF));
    vecs.push_back(mk("m_rsp",   1,'h200, 0,0,0,0,0, 0,0,'h99,         0,0,0,0,0,0,     0,1,1, 0,0,0,       0,0,0));
    vecs.push_back(mk("m_rv",    1,'h200, 0,0,0,0,0, 0,1,'h55,         1,0,0,1,0,'h55,  0,1,1, 0,0,0,       0,0,0));
    vecs.push_back(mk("f2_req",  0,0,     0,0,0,0,0, 1,0,0,            0,0,0,0,0,0,     1,1,0, 1,0,'h200,   0,0,0));
    vecs.push_back(mk("f2_rv",   0,0,     0,0,0,0,0, 0,1,'h77,         0,0,1,0,'h77,0,  0,1,0, 0,0,0,       0,0,0));
    vecs.push_back(mk("f2_idle", 0,0,     0,0,0,0,0, 0,0,0,            0,0,0,0,0,0,     0,0,0, 0,0,0,       0,0,0));
    // Spurious handshakes: bus_rvalid/bus_gnt in IDLE, bus_gnt in RSP.
    vecs.push_back(mk("sp_idle", 0,0,     0,0,0,0,0, 1,1,'hAAAA5555,   0,0,0,0,0,0,     0,0,0, 0,0,0,       0,0,0));
    vecs.push_back(mk("sp_gnt",  1,'h300, 0,0,0,0,0, 0,0,0,            1,0,0,0,0,0,     0,0,0, 0,0,0,       0,0,0));
    vecs.push_back(mk("sp_req",  0,0,     0,0,0,0,0, 1,0,0,            0,0,0,0,0,0,     1,1,0, 1,0,'h300,   0,0,0));
    vecs.push_back(mk("sp_rsp1", 0,0,     0,0,0,0,0, 1,0,'h5A5A,       0,0,0,0,0,0,     0,1,0, 0,0,0,       0,0,0));
    vecs.push_back(mk("sp_rsp2", 0,0,     0,0,0,0,0, 1,0,0,            0,0,0,0,0,0,     0,1,0, 0,0,0,       0,0,0));
    vecs.push_back(mk("sp_rv",   0,0,     0,0,0,0,0, 0,1,'h1234,       0,0,1,0,'h1234,0,0,1,0, 0,0,0,       0,0,0));
    vecs.push_back(mk("sp_done", 0,0,     0,0,0,0,0, 0,0,0,            0,0,0,0,0,0,     0,0,0, 0,0,0,       0,0,0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Starvation relief: both requesters held high, bus answers every cycle.
    if_req = 1; if_addr = 32'h400; mem_req = 1; mem_we = 0; mem_addr = 32'h500;
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("one_gnt", {if_gnt, mem_gnt} == 2'b11, 1'b0);
      if (bus_req && own_q.size() < 10) begin
        own_q.push_back(int'(owner));
        addr_q.push_back(bus_addr);
      end
      @(posedge clk); #1;
    end
    chk("starve_grants", own_q.size(), 10);
    foreach (own_q[i]) begin
      chk($sformatf("starve_owner_%0d", i), own_q[i], (i % 5 == 4) ? 0 : 1);
      chk($sformatf("starve_addr_%0d", i), addr_q[i], (i % 5 == 4) ? 32'h400 : 32'h500);
    end
    if_req = 0; mem_req = 0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
      if (busy) begin @(posedge clk); #1; end
    end while (busy && waited < 6);
    chk("starve_drain", busy, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;

    // Reset asserted while the bus request is pending.
    if_req = 1; if_addr = 32'h600;
    @(negedge clk);
    chk("rst_op_gnt", if_gnt, 1'b1);
    @(posedge clk); #1;
    if_req = 0;
    @(negedge clk);
    chk("rst_op_busreq", bus_req, 1'b1);
    #1 rst_n = 0;
    #1 chk("rst_op_drop", {bus_req, busy, owner}, 3'b000);
    if_req = 1;
    #1 chk("rst_op_nogrant", {if_gnt, mem_gnt}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    #2 if_req = 0; rst_n = 1;
    @(posedge clk); #1;
    bus_rvalid = 1; bus_rdata = 32'h99;
    @(negedge clk);
    chk("rst_late_rv", {if_rvalid, mem_rvalid, busy, if_rdata, mem_rdata}, '0);
    @(posedge clk); #1;
    bus_rvalid = 0; if_req = 1; if_addr = 32'h700;
    @(negedge clk);
    chk("rst_after_gnt", if_gnt, 1'b1);
    @(posedge clk); #1;
    if_req = 0; bus_gnt = 1;
    @(negedge clk);
    chk("rst_after_req", {bus_req, bus_we, bus_addr}, {2'b10, 32'h700});
    @(posedge clk); #1;
    bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'hABC;
    @(negedge clk);
    chk("rst_after_rv", {if_rvalid, mem_rvalid, if_rdata}, {2'b10, 32'hABC});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("rst_after_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
